ths8200_config_ctrl: RTL and testbench

Sequencer that walks the THS8200 initialization table after power-up and issues one I2C register write per table entry. It drives the table's index input and absorbs the table's two-cycle registered read latency. Each `{reg_addr, data}` word goes to the shared I2C write master through a request/done handshake. The block sits between the table ROM and the I2C master, and reports `config_done` / `config_err` to video-path enable logic.

---
 rtl/ths8200_config_ctrl_if.sv | 34 +++
 rtl/ths8200_config_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ths8200_config_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ths8200_config_ctrl_if.sv
// Bus bundle between the THS8200 config sequencer, its init-table ROM, the I2C write master
// and the video-path enable logic.
interface ths8200_config_ctrl_if;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DEV_W  = 7;

   logic                start;
   logic [IDX_W-1:0]    config_index;
   logic [WORD_W-1:0]   config_data;
   logic                i2c_req;
   logic [DEV_W-1:0]    i2c_dev_addr;
   logic [BYTE_W-1:0]   i2c_reg_addr;
   logic [BYTE_W-1:0]   i2c_wr_data;
   logic                i2c_done;
   logic                i2c_nack;
   logic                busy;
   logic                config_done;
   logic                config_err;
   logic [IDX_W-1:0]    err_index;

   modport master (
      input  start, config_data, i2c_done, i2c_nack,
      output config_index, i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_wr_data,
             busy, config_done, config_err, err_index
   );

   modport slave (
      output start, config_data, i2c_done, i2c_nack,
      input  config_index, i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_wr_data,
             busy, config_done, config_err, err_index
   );
endinterface

// File: rtl/ths8200_config_ctrl.sv
// THS8200 power-up sequencer: walks the init table and issues one I2C register write per entry.
// Define THS8200_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before aborting.
module ths8200_config_ctrl #(
   parameter int unsigned LUT_SIZE    = 126,
   parameter logic [6:0]  DEV_ADDR    = 7'h20,
   parameter logic [31:0] POWERUP_DLY = 32'd50_000_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input logic                   clk,
   input logic                   rst_n,
   ths8200_config_ctrl_if.master cfg
);

   localparam int unsigned IDX_W  = 8;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned LAT_W  = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);
   localparam logic [LAT_W-1:0] ROM_LAT  = LAT_W'(2);

   if (LUT_SIZE < 1 || LUT_SIZE > 256 || POWERUP_DLY == 32'd0 || MAX_RETRY > 255) begin : g_bad_param
      $error("ths8200_config_ctrl: LUT_SIZE must be 1..256, POWERUP_DLY >= 1, MAX_RETRY <= 255");
   end

   typedef enum logic [2:0] {S_PWRUP, S_FETCH, S_REQ, S_NEXT, S_DONE, S_ERROR} state_t;

   state_t              r_state, w_state;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic [LAT_W-1:0]    r_lat, w_lat;
   logic [IDX_W-1:0]    r_idx, w_idx;
   logic [IDX_W-1:0]    r_eidx, w_eidx;
   logic [BYTE_W-1:0]   r_reg, w_reg;
   logic [BYTE_W-1:0]   r_dat, w_dat;
   logic                r_req, w_req;
   logic                r_last, w_last;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
   logic                r_err, w_err;
`ifdef THS8200_CFG_RETRY_EN
   localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0]  r_retry, w_retry;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_PWRUP;
         r_cnt   <= '0;
         r_lat   <= '0;
         r_idx   <= '0;
         r_eidx  <= '0;
         r_reg   <= '0;
         r_dat   <= '0;
         r_req   <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
`ifdef THS8200_CFG_RETRY_EN
         r_retry <= '0;
`endif
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_lat   <= w_lat;
         r_idx   <= w_idx;
         r_eidx  <= w_eidx;
         r_reg   <= w_reg;
         r_dat   <= w_dat;
         r_req   <= w_req;
         r_last  <= w_last;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_err   <= w_err;
`ifdef THS8200_CFG_RETRY_EN
         r_retry <= w_retry;
`endif
      end
   end

   // Next-state logic; r_lat counts cycles since config_index last changed (ROM read latency)
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_lat   = r_lat;
      w_idx   = r_idx;
      w_eidx  = r_eidx;
      w_reg   = r_reg;
      w_dat   = r_dat;
      w_req   = r_req;
      w_last  = r_last;
`ifdef THS8200_CFG_RETRY_EN
      w_retry = r_retry;
`endif
      case (r_state)
         S_PWRUP: begin
            if (r_cnt == POWERUP_DLY - 32'd1) begin
               w_state = S_FETCH;
               w_idx   = '0;
               w_lat   = '0;
            end else begin
               w_cnt = r_cnt + 32'd1;
            end
         end
         S_FETCH: begin
`ifdef THS8200_CFG_RETRY_EN
            w_retry = '0;
`endif
            if (r_lat == ROM_LAT) begin
               w_reg   = cfg.config_data[15:8];
               w_dat   = cfg.config_data[7:0];
               w_req   = 1'b1;
               w_state = S_REQ;
            end else begin
               w_lat = r_lat + 1'b1;
            end
         end
         S_REQ: begin
            // Request low while in REQ means a NACKed write is being reissued
            if (!r_req) begin
               w_req = 1'b1;
            end else if (cfg.i2c_done) begin
               w_req = 1'b0;
               if (!cfg.i2c_nack) begin
                  w_state = S_NEXT;
                  w_last  = (r_idx == LAST_IDX);
                  w_lat   = '0;
                  if (r_idx != LAST_IDX) begin
                     w_idx = r_idx + 1'b1;
                  end
               end else begin
`ifdef THS8200_CFG_RETRY_EN
                  if (32'(r_retry) < MAX_RETRY) begin
                     w_retry = r_retry + 1'b1;
                  end else begin
                     w_state = S_ERROR;
                     w_eidx  = r_idx;
                  end
`else
                  w_state = S_ERROR;
                  w_eidx  = r_idx;
`endif
               end
            end
         end
         S_NEXT: begin
            w_lat   = r_lat + 1'b1;
            w_state = r_last ? S_DONE : S_FETCH;
         end
         S_DONE, S_ERROR: begin
            if (cfg.start) begin
               w_state = S_FETCH;
               w_idx   = '0;
               w_lat   = '0;
`ifdef THS8200_CFG_RETRY_EN
               w_retry = '0;
`endif
            end
         end
         default: w_state = S_PWRUP;
      endcase
      w_busy = (w_state != S_DONE) && (w_state != S_ERROR);
      w_done = (w_state == S_DONE);
      w_err  = (w_state == S_ERROR);
   end

   assign cfg.config_index = r_idx;
   assign cfg.i2c_req      = r_req;
   assign cfg.i2c_dev_addr = DEV_ADDR;
   assign cfg.i2c_reg_addr = r_reg;
   assign cfg.i2c_wr_data  = r_dat;
   assign cfg.busy         = r_busy;
   assign cfg.config_done  = r_done;
   assign cfg.config_err   = r_err;
   assign cfg.err_index    = r_eidx;

endmodule

// File: tb/tb_ths8200_config_ctrl.sv
// Self-checking bench for ths8200_config_ctrl: ROM and I2C slave models, table-driven NACK
// scenarios, randomized ack latency / NACK placement, and start/reset corner sequences.
module tb_ths8200_config_ctrl;
   localparam int LUT  = 126;
   localparam int DLY  = 16;
   localparam int MAXR = 3;
`ifdef THS8200_CFG_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   typedef struct {
      logic [7:0]  idx;
      logic [15:0] word;
      int          req_cyc;
      int          done_cyc;
      bit          nacked;
   } xfer_t;

   typedef struct {
      int nack_idx;
      int nack_cnt;
      bit exp_done;
      bit exp_err;
      int exp_eidx;
      int exp_n;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc;
   int   n_chk = 0;
   int   n_fail = 0;

   int   nack_idx = -1;
   int   nack_cnt = 0;
   bit   rand_dly = 1'b0;

   xfer_t        log_q[$];
   logic [23:0]  exp_q[$];
   bit           m_done, m_err;
   int           m_eidx;

   xfer_t        cur;
   bit           in_xfer;
   int           ack_cnt;
   int           nack_given;
   int           unstable;
   logic [15:0]  rom_p1;

   ths8200_config_ctrl_if cfg ();

   ths8200_config_ctrl #(
      .LUT_SIZE    (LUT),
      .DEV_ADDR    (7'h20),
      .POWERUP_DLY (32'(DLY)),
      .MAX_RETRY   (MAXR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (cfg)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [15:0] rom_word(input logic [7:0] i);
      case (i)
         8'd0:    return 16'h0301;
         8'd53:   return 16'h3889;
         8'd125:  return 16'h8500;
         default: return {8'(i + 8'd4), 8'(i * 8'd7) ^ 8'h5A};
      endcase
   endfunction

   // Init-table ROM with two registered read stages
   always @(posedge clk) begin
      rom_p1          <= rom_word(cfg.config_index);
      cfg.config_data <= rom_p1;
   end

   // I2C write master model: logs each request, holds it ack_cnt cycles, then pulses done
   always @(negedge clk) begin
      cfg.i2c_done = 1'b0;
      cfg.i2c_nack = 1'b0;
      if (!rst_n) begin
         log_q.delete();
         in_xfer    = 1'b0;
         nack_given = 0;
         unstable   = 0;
      end else if (!cfg.i2c_req) begin
         in_xfer = 1'b0;
      end else if (!in_xfer) begin
         in_xfer      = 1'b1;
         cur.idx      = cfg.config_index;
         cur.word     = {cfg.i2c_reg_addr, cfg.i2c_wr_data};
         cur.req_cyc  = cyc;
         cur.done_cyc = 0;
         cur.nacked   = 1'b0;
         ack_cnt      = rand_dly ? int'($urandom_range(6, 1)) : 5;
      end else if (ack_cnt > 0) begin
         if ({cfg.i2c_reg_addr, cfg.i2c_wr_data} != cur.word) unstable++;
         ack_cnt--;
         if (ack_cnt == 0) begin
            cur.nacked = (nack_idx == int'(cur.idx)) && (nack_given < nack_cnt);
            if (cur.nacked) nack_given++;
            cur.done_cyc = cyc;
            cfg.i2c_done = 1'b1;
            cfg.i2c_nack = cur.nacked;
            log_q.push_back(cur);
         end
      end
   end

   // Expected write stream from the table rules: one write per entry, NACKed entry repeated
   function automatic void build_expected(input int nidx, input int ncnt);
      int limit;
      int tries;
      limit  = RETRY ? MAXR + 1 : 1;
      exp_q.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      m_eidx = 0;
      for (int i = 0; i < LUT; i++) begin
         tries = (i != nidx) ? 1 : ((ncnt >= limit) ? limit : ncnt + 1);
         for (int k = 0; k < tries; k++) exp_q.push_back({8'(i), rom_word(8'(i))});
         if (i == nidx && ncnt >= limit) begin
            m_err  = 1'b1;
            m_eidx = i;
            return;
         end
      end
      m_done = 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      cfg.start = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_end(input string tag, output int end_cyc);
      int n;
      n = 0;
      while (!(cfg.config_done || cfg.config_err) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      end_cyc = cyc;
      chk({tag, "_finished"}, 32'(cfg.config_done || cfg.config_err), 32'd1);
   endtask

   task automatic wait_index(input int idx, input bit need_req, output bit hit);
      hit = 1'b0;
      for (int n = 0; n < 4000 && !hit; n++) begin
         @(negedge clk);
         if (int'(cfg.config_index) == idx && (!need_req || cfg.i2c_req)) hit = 1'b1;
      end
   endtask

   task automatic check_results(input string tag, input bit e_done, input bit e_err,
                                input int e_eidx, input int e_n, input int end_cyc);
      int mism;
      int gaps;
      int last;
      mism = 0;
      gaps = 0;
      chk({tag, "_config_done"}, 32'(cfg.config_done), 32'(e_done));
      chk({tag, "_config_err"},  32'(cfg.config_err),  32'(e_err));
      chk({tag, "_err_index"},   32'(cfg.err_index),   32'(e_eidx));
      chk({tag, "_busy"},        32'(cfg.busy),        32'd0);
      chk({tag, "_nreq"},        32'(log_q.size()),    32'(e_n));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         if ({log_q[i].idx, log_q[i].word} !== exp_q[i]) mism++;
      chk({tag, "_write_mismatches"}, 32'(mism), 32'd0);
      for (int i = 1; i < log_q.size(); i++)
         if (log_q[i].req_cyc - log_q[i-1].done_cyc != (log_q[i-1].nacked ? 2 : 4)) gaps++;
      chk({tag, "_gap_violations"}, 32'(gaps), 32'd0);
      chk({tag, "_unstable_req"}, 32'(unstable), 32'd0);
      if (log_q.size() > 0) begin
         chk({tag, "_first_req_cyc"}, 32'(log_q[0].req_cyc), 32'(DLY + 3));
         last = log_q.size() - 1;
         if (e_done) chk({tag, "_done_latency"}, 32'(end_cyc - log_q[last].done_cyc), 32'd2);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec[3];
      int   end_cyc;
      int   s_cyc;
      int   n;
      bit   hit;

      vec[0] = '{-1, 0,    1'b1,   1'b0,    0,               126};
      vec[1] = '{53, 2,    RETRY,  !RETRY,  RETRY ? 0 : 53,  RETRY ? 128 : 54};
      vec[2] = '{10, 1000, 1'b0,   1'b1,    10,              RETRY ? 14 : 11};

      // Reset values, then busy on the first edge after release
      cfg.start = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_config_index", 32'(cfg.config_index), 32'd0);
      chk("rst_i2c_req",      32'(cfg.i2c_req),      32'd0);
      chk("rst_reg_addr",     32'(cfg.i2c_reg_addr), 32'd0);
      chk("rst_wr_data",      32'(cfg.i2c_wr_data),  32'd0);
      chk("rst_busy",         32'(cfg.busy),         32'd0);
      chk("rst_config_done",  32'(cfg.config_done),  32'd0);
      chk("rst_config_err",   32'(cfg.config_err),   32'd0);
      chk("rst_err_index",    32'(cfg.err_index),    32'd0);
      chk("dev_addr",         32'(cfg.i2c_dev_addr), 32'h20);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("busy_after_release", 32'(cfg.busy), 32'd1);

      // Table-driven NACK scenarios
      for (int v = 0; v < 3; v++) begin
         nack_idx = vec[v].nack_idx;
         nack_cnt = vec[v].nack_cnt;
         rand_dly = 1'b0;
         do_reset();
         build_expected(nack_idx, nack_cnt);
         wait_end($sformatf("vec%0d", v), end_cyc);
         check_results($sformatf("vec%0d", v), vec[v].exp_done, vec[v].exp_err,
                       vec[v].exp_eidx, vec[v].exp_n, end_cyc);
      end

      // start in ERROR clears the error and re-runs without power-up delay
      cfg.start = 1'b1;
      @(negedge clk);
      cfg.start = 1'b0;
      chk("err_start_clear", 32'(cfg.config_err),   32'd0);
      chk("err_start_index", 32'(cfg.config_index), 32'd0);
      chk("err_start_busy",  32'(cfg.busy),         32'd1);
      wait_end("err_rerun", end_cyc);
      chk("err_rerun_err",   32'(cfg.config_err), 32'd1);
      chk("err_rerun_eidx",  32'(cfg.err_index),  32'd10);

      // Randomized ack latency and NACK placement against the table-rule model
      for (int r = 0; r < 3; r++) begin
         nack_idx = int'($urandom_range(LUT - 1, 0));
         nack_cnt = int'($urandom_range(5, 0));
         rand_dly = 1'b1;
         do_reset();
         build_expected(nack_idx, nack_cnt);
         wait_end($sformatf("rand%0d", r), end_cyc);
         check_results($sformatf("rand%0d_i%0d_n%0d", r, nack_idx, nack_cnt),
                       m_done, m_err, m_eidx, exp_q.size(), end_cyc);
      end

      // start while busy is ignored
      nack_idx = -1;
      nack_cnt = 0;
      rand_dly = 1'b0;
      do_reset();
      build_expected(-1, 0);
      wait_index(40, 1'b0, hit);
      chk("busy_start_reached_idx40", 32'(hit), 32'd1);
      cfg.start = 1'b1;
      @(negedge clk);
      cfg.start = 1'b0;
      wait_end("busy_start", end_cyc);
      check_results("busy_start", 1'b1, 1'b0, 0, LUT, end_cyc);

      // start in DONE: done clears next cycle, request three edges after start
      cfg.start = 1'b1;
      s_cyc = cyc + 1;
      @(negedge clk);
      cfg.start = 1'b0;
      chk("done_start_clear", 32'(cfg.config_done), 32'd0);
      chk("done_start_busy",  32'(cfg.busy),        32'd1);
      n = 0;
      while (!cfg.i2c_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_start_req_lat", 32'(cyc - s_cyc),      32'd3);
      chk("done_start_reg",     32'(cfg.i2c_reg_addr), 32'h03);
      chk("done_start_data",    32'(cfg.i2c_wr_data),  32'h01);
      wait_end("done_rerun", end_cyc);
      chk("done_rerun_done", 32'(cfg.config_done), 32'd1);
      chk("done_rerun_nreq", 32'(log_q.size()),     32'(2 * LUT));

      // Reset mid-transfer: request drops asynchronously, sequence restarts from power-up
      do_reset();
      wait_index(70, 1'b1, hit);
      chk("midrst_reached_idx70", 32'(hit), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_req_async",  32'(cfg.i2c_req),      32'd0);
      chk("midrst_index",      32'(cfg.config_index), 32'd0);
      chk("midrst_busy",       32'(cfg.busy),         32'd0);
      do_reset();
      n = 0;
      while (log_q.size() == 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_seen_write", 32'(log_q.size() > 0), 32'd1);
      if (log_q.size() > 0) begin
         chk("midrst_first_idx",  32'(log_q[0].idx),     32'd0);
         chk("midrst_first_word", 32'(log_q[0].word),    32'h0301);
         chk("midrst_first_cyc",  32'(log_q[0].req_cyc), 32'(DLY + 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
